pong_input_arbiter: RTL and testbench

Parametrised successor to the fixed-mode input bridge. Takes raw push-buttons and decoded UART control levels for N_PLAYERS paddles and produces clean per-player up/down levels plus a single start pulse. Each player has a source FSM that selects between button and UART at runtime: forced, or auto-switched on activity with idle fallback. Sits between board/UART pins and pong_logic/start_menu in the clk domain.

---
 rtl/pong_input_pkg.sv | 25 ++
 rtl/pong_input_arbiter_if.sv | 25 ++
 rtl/pong_input_arbiter_debounce.sv | 41 ++++
 rtl/pong_input_arbiter.sv | 124 ++++++++++++
 tb/tb_pong_input_arbiter.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/pong_input_pkg.sv
// rtl/pong_input_pkg.sv - shared encodings and bit-layout helpers for the pong input arbiter
package pong_input_pkg;

  typedef enum logic {
    SRC_BTN  = 1'b0,
    SRC_UART = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    LOCK_AUTO = 2'b00,
    LOCK_BTN  = 2'b01,
    LOCK_UART = 2'b10,
    LOCK_RSVD = 2'b11
  } lock_e;

  // Per-player bit positions inside btn_raw / uart_ctrl.
  function automatic int up_bit(input int p);
    return 2 * p;
  endfunction

  function automatic int dn_bit(input int p);
    return 2 * p + 1;
  endfunction

endpackage

// File: rtl/pong_input_arbiter_if.sv
// rtl/pong_input_arbiter_if.sv - pin-side and game-side signal bundle of the input arbiter
interface pong_input_arbiter_if #(
  parameter int N_PLAYERS = 2
);
  logic [2*N_PLAYERS-1:0] btn_raw;
  logic                   btn_start;
  logic [2*N_PLAYERS-1:0] uart_ctrl;
  logic                   uart_start;
  logic [1:0]             mode_lock;
  logic [N_PLAYERS-1:0]   up;
  logic [N_PLAYERS-1:0]   down;
  logic                   start_trigger;
  logic [N_PLAYERS-1:0]   active_src;
  logic                   src_change;

  modport master (
    output btn_raw, btn_start, uart_ctrl, uart_start, mode_lock,
    input  up, down, start_trigger, active_src, src_change
  );

  modport slave (
    input  btn_raw, btn_start, uart_ctrl, uart_start, mode_lock,
    output up, down, start_trigger, active_src, src_change
  );
endinterface

// File: rtl/pong_input_arbiter_debounce.sv
// rtl/pong_input_arbiter_debounce.sv - 2-FF synchroniser plus stable-level counter for one button
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    sync_d  = {sync_q[0], raw};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) level_d = sync_q[1];
      else                  cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
endmodule

// File: rtl/pong_input_arbiter.sv
// rtl/pong_input_arbiter.sv - per-player button/UART source selection, clean paddle levels and start pulse
module pong_input_arbiter
  import pong_input_pkg::*;
#(
  parameter int N_PLAYERS       = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int IDLE_CYCLES     = 250000000,
  parameter int SRC_DEFAULT     = 1
) (
  input logic                  clk,
  input logic                  rst,
  pong_input_arbiter_if.slave  bus
);
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);
  localparam int HW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(DEBOUNCE_CYCLES);
  localparam src_e DEFAULT_SRC = (SRC_DEFAULT != 0) ? SRC_UART : SRC_BTN;

  logic [2*N_PLAYERS-1:0] btn_db;
  logic                   start_db;
  logic [N_PLAYERS-1:0]   switch_evt;
  lock_e                  lock;

  assign lock = lock_e'(bus.mode_lock);

  for (genvar i = 0; i < 2*N_PLAYERS; i++) begin : g_db
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst(rst), .raw(bus.btn_raw[i]), .level(btn_db[i])
    );
  end

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .raw(bus.btn_start), .level(start_db)
  );

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    localparam int UB = up_bit(p);
    localparam int DB = dn_bit(p);

    src_e          src_q, src_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          up_q, up_d, down_q, down_d;
    logic          btn_act, uart_act, cur_act, oth_act, sel_up, sel_dn, sw;

    assign btn_act  = btn_db[UB] | btn_db[DB];
    assign uart_act = bus.uart_ctrl[UB] | bus.uart_ctrl[DB];

    always_comb begin
      cur_act = (src_q == SRC_UART) ? uart_act : btn_act;
      oth_act = (src_q == SRC_UART) ? btn_act  : uart_act;
      src_d   = src_q;
      if (lock == LOCK_BTN)                                src_d = SRC_BTN;
      else if (lock == LOCK_UART)                          src_d = SRC_UART;
      else if (oth_act && !cur_act)                        src_d = src_e'(~src_q);
      else if (idle_q == IDLE_MAX && src_q != DEFAULT_SRC) src_d = DEFAULT_SRC;
      sw = (src_d != src_q);

      if (sw || cur_act)         idle_d = '0;
      else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
      else                       idle_d = idle_q;

      // Outputs blank for the switch cycle so a level never leaks across sources.
      sel_up = (src_q == SRC_UART) ? bus.uart_ctrl[UB] : btn_db[UB];
      sel_dn = (src_q == SRC_UART) ? bus.uart_ctrl[DB] : btn_db[DB];
      up_d   = !sw && sel_up && !sel_dn;
      down_d = !sw && sel_dn && !sel_up;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        src_q  <= DEFAULT_SRC;
        idle_q <= '0;
        up_q   <= 1'b0;
        down_q <= 1'b0;
      end else begin
        src_q  <= src_d;
        idle_q <= idle_d;
        up_q   <= up_d;
        down_q <= down_d;
      end
    end

    assign switch_evt[p]     = sw;
    assign bus.up[p]         = up_q;
    assign bus.down[p]       = down_q;
    assign bus.active_src[p] = src_q;
  end

  logic          start_prev_q;
  logic [HW-1:0] hold_q, hold_d;
  logic          start_trig_q, start_trig_d;
  logic          src_change_q, src_change_d;

  // Edges arriving during holdoff are consumed, not deferred.
  always_comb begin
    hold_d       = hold_q;
    start_trig_d = 1'b0;
    src_change_d = |switch_evt;
    if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end else if ((start_db && !start_prev_q) || bus.uart_start) begin
      start_trig_d = 1'b1;
      hold_d       = HOLD_INIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev_q <= 1'b0;
      hold_q       <= '0;
      start_trig_q <= 1'b0;
      src_change_q <= 1'b0;
    end else begin
      start_prev_q <= start_db;
      hold_q       <= hold_d;
      start_trig_q <= start_trig_d;
      src_change_q <= src_change_d;
    end
  end

  assign bus.start_trigger = start_trig_q;
  assign bus.src_change    = src_change_q;
endmodule

// File: tb/tb_pong_input_arbiter.sv
// tb/tb_pong_input_arbiter.sv - directed scoreboard bench for pong_input_arbiter
module tb_pong_input_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;

  always #5 clk = ~clk;

  pong_input_arbiter_if #(.N_PLAYERS(2)) bus ();

  pong_input_arbiter #(
    .N_PLAYERS(2), .DEBOUNCE_CYCLES(8), .IDLE_CYCLES(32), .SRC_DEFAULT(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    string      tag;
    logic [1:0] up;
    logic [1:0] down;
    logic [1:0] act;
    logic       chg;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) if (bus.start_trigger === 1'b1) start_cnt++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] u, input logic [1:0] d,
                      input logic [1:0] a, input logic c);
    exp_t e;
    e.tag = tag; e.up = u; e.down = d; e.act = a; e.chg = c;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_up"},   {6'd0, bus.up},         {6'd0, e.up});
    chk({e.tag, "_down"}, {6'd0, bus.down},       {6'd0, e.down});
    chk({e.tag, "_src"},  {6'd0, bus.active_src}, {6'd0, e.act});
    chk({e.tag, "_chg"},  {7'd0, bus.src_change}, {7'd0, e.chg});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.btn_raw = '0; bus.btn_start = 1'b0; bus.uart_ctrl = '0;
    bus.uart_start = 1'b0; bus.mode_lock = 2'b00;
    cyc(2);
    push("reset", 2'b00, 2'b00, 2'b11, 1'b0); pop_cmp();
    chk("reset_start", {7'd0, bus.start_trigger}, 8'd0);
    rst = 1'b0;
    cyc(1);

    // UART levels through the default source, one register of latency.
    bus.uart_ctrl = 4'b0001; push("uart_up", 2'b01, 2'b00, 2'b11, 1'b0); cyc(1); pop_cmp();
    bus.uart_ctrl = 4'b0011; push("uart_both", 2'b00, 2'b00, 2'b11, 1'b0); cyc(1); pop_cmp();
    bus.uart_ctrl = 4'b1000; push("uart_p1_dn", 2'b00, 2'b10, 2'b11, 1'b0); cyc(1); pop_cmp();
    bus.uart_ctrl = 4'b0000; push("uart_idle", 2'b00, 2'b00, 2'b11, 1'b0); cyc(1); pop_cmp();

    // 5-cycle glitch must be swallowed by the debouncer.
    bus.btn_raw = 4'b0001; cyc(5); bus.btn_raw = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      push("glitch", 2'b00, 2'b00, 2'b11, 1'b0); cyc(1); pop_cmp();
    end

    // Held press: accepted after 2+8 edges, switch cycle blanks, level follows.
    bus.btn_raw = 4'b0001;
    push("btn_pre", 2'b00, 2'b00, 2'b11, 1'b0); cyc(10); pop_cmp();
    push("btn_switch", 2'b00, 2'b00, 2'b10, 1'b1); cyc(1); pop_cmp();
    push("btn_up", 2'b01, 2'b00, 2'b10, 1'b0); cyc(1); pop_cmp();
    push("btn_hold", 2'b01, 2'b00, 2'b10, 1'b0); cyc(9); pop_cmp();

    // Release: idle fallback to UART after 32 inactive cycles.
    bus.btn_raw = 4'b0000;
    push("rel_lag", 2'b01, 2'b00, 2'b10, 1'b0); cyc(10); pop_cmp();
    push("rel_low", 2'b00, 2'b00, 2'b10, 1'b0); cyc(1); pop_cmp();
    push("idle_pre", 2'b00, 2'b00, 2'b10, 1'b0); cyc(30); pop_cmp();
    push("idle_back", 2'b00, 2'b00, 2'b11, 1'b1); cyc(1); pop_cmp();
    push("idle_after", 2'b00, 2'b00, 2'b11, 1'b0); cyc(1); pop_cmp();

    // Forced button: both players switch, no idle reversion.
    bus.mode_lock = 2'b01;
    push("lock_btn", 2'b00, 2'b00, 2'b00, 1'b1); cyc(1); pop_cmp();
    for (int i = 0; i < 60; i++) begin
      push("lock_hold", 2'b00, 2'b00, 2'b00, 1'b0); cyc(1); pop_cmp();
    end
    bus.mode_lock = 2'b10;
    push("lock_uart", 2'b00, 2'b00, 2'b11, 1'b1); cyc(1); pop_cmp();
    bus.uart_ctrl = 4'b0011; push("lock_both", 2'b00, 2'b00, 2'b11, 1'b0); cyc(1); pop_cmp();
    bus.uart_ctrl = 4'b0100; push("lock_p1_up", 2'b10, 2'b00, 2'b11, 1'b0); cyc(1); pop_cmp();
    bus.uart_ctrl = 4'b0000; bus.mode_lock = 2'b00;
    push("lock_off", 2'b00, 2'b00, 2'b11, 1'b0); cyc(2); pop_cmp();

    // Start: coincident UART pulse and debounced button edge give one pulse.
    bus.btn_start = 1'b1;
    cyc(10);
    chk("start_pre", {7'd0, bus.start_trigger}, 8'd0);
    bus.uart_start = 1'b1; cyc(1);
    chk("start_pulse", {7'd0, bus.start_trigger}, 8'd1);
    bus.uart_start = 1'b0; cyc(1);
    chk("start_single", {7'd0, bus.start_trigger}, 8'd0);
    cyc(1);
    bus.uart_start = 1'b1; cyc(1);
    chk("start_holdoff", {7'd0, bus.start_trigger}, 8'd0);
    bus.uart_start = 1'b0; cyc(15);
    chk("start_cnt1", 8'(start_cnt), 8'd1);
    bus.uart_start = 1'b1; cyc(1);
    chk("start_rearm", {7'd0, bus.start_trigger}, 8'd1);
    bus.uart_start = 1'b0; bus.btn_start = 1'b0; cyc(12);
    chk("start_cnt2", 8'(start_cnt), 8'd2);

    // Reset mid-debounce clears everything and restarts the debounce window.
    bus.mode_lock = 2'b01;
    push("pre_rst_lock", 2'b00, 2'b00, 2'b00, 1'b1); cyc(1); pop_cmp();
    bus.btn_raw = 4'b0001; cyc(5);
    #2 rst = 1'b1;
    #1 push("mid_rst", 2'b00, 2'b00, 2'b11, 1'b0); pop_cmp();
    bus.mode_lock = 2'b00;
    cyc(1); rst = 1'b0;
    push("rst_pre", 2'b00, 2'b00, 2'b11, 1'b0); cyc(10); pop_cmp();
    push("rst_switch", 2'b00, 2'b00, 2'b10, 1'b1); cyc(1); pop_cmp();
    push("rst_up", 2'b01, 2'b00, 2'b10, 1'b0); cyc(1); pop_cmp();

    bus.btn_raw = 4'b0000;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
